// File: rtl/seg14_pkg.sv
// seg14_pkg: digit count, character codes, 14-segment glyph table and FSM state type
package seg14_pkg;
  localparam int NUM_DIGITS = 12;
  localparam int NUM_GLYPHS = 38;
  localparam logic [5:0] CODE_SPACE   = 6'd0;
  localparam logic [5:0] CODE_UNKNOWN = 6'd63;
  localparam logic [13:0] GLYPH [NUM_GLYPHS] = '{
    14'b00000000000000, 14'b11101111000000, 14'b11110001010010, 14'b10011100000000,
    14'b11110000010010, 14'b10011111000000, 14'b10001110000000, 14'b10111101000000,
    14'b01101111000000, 14'b10010000010010, 14'b01111000000000, 14'b00001110001001,
    14'b00011100000000, 14'b01101100101000, 14'b01101100100001, 14'b11111100000000,
    14'b11001111000000, 14'b11111100000001, 14'b11001111000001, 14'b10110111000000,
    14'b10000000010010, 14'b01111100000000, 14'b00001100001100, 14'b01101100000101,
    14'b00000000101101, 14'b00000000101010, 14'b10010000001100, 14'b11101100100001,
    14'b11111100001100, 14'b01100000001000, 14'b11011011000000, 14'b11110001000000,
    14'b01100111000000, 14'b10110111000000, 14'b10111111000000, 14'b11100000000000,
    14'b11111111000000, 14'b11110111000000
  };
  typedef enum logic {HUNT, CAPTURE} state_t;
endpackage

// File: rtl/seg14_glyph_decode.sv
// seg14_glyph_decode: combinational segment-pattern to character-code lookup with unknown flag
module seg14_glyph_decode
  import seg14_pkg::*;
(
  input  logic [13:0] segm,
  output logic [5:0]  code,
  output logic        unknown
);
  // scan from the highest code down so the lowest matching code wins (letters over look-alike digits)
  always_comb begin
    code = CODE_UNKNOWN;
    unknown = 1'b1;
    for (int i = NUM_GLYPHS - 1; i >= 0; i--) begin
      if (segm == GLYPH[i]) begin
        code = 6'(i);
        unknown = 1'b0;
      end
    end
  end
endmodule

// File: rtl/seg14_scan_decoder.sv
// seg14_scan_decoder: rebuilds 12-character frames from a scanned 14-segment bus; define SEG14_DEC_ERRCNT_EN for the saturating error counter
module seg14_scan_decoder
  import seg14_pkg::*;
#(
  parameter int STABLE_CYC  = 1,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] sel,
  input  logic [13:0] segm,
  input  logic [3:0]  rd_addr,
  output logic [5:0]  rd_code,
  output logic        frame_done,
  output logic        locked,
  output logic        err_seq,
  output logic        err_onehot,
  output logic        err_glyph,
  output logic [7:0]  err_cnt
);
  state_t      state_q, state_d;
  logic [11:0] sel_q;
  logic [13:0] segm_q;
  logic [3:0]  run_q, run_d, slot, exp_q, exp_d;
  logic [15:0] to_q, to_d;
  logic [5:0]  code;
  logic        unk, same, one_hot, accept, multi_err;
  logic        wr, commit, locked_d, done_d, seq_d, oh_d, gl_d;
  logic [5:0]  shadow [NUM_DIGITS];
  logic [5:0]  out_buf [NUM_DIGITS];

  seg14_glyph_decode u_glyph (.segm(segm), .code(code), .unknown(unk));

  // run length of identical sel/segm cycles; a run is accepted once, on the cycle it reaches STABLE_CYC; a held multi-hot select reports once
  always_comb begin
    same = sel == sel_q && segm == segm_q;
    run_d = !same ? 4'd1 : run_q == 4'd15 ? run_q : run_q + 4'd1;
    one_hot = $onehot(sel);
    accept = one_hot && run_d == 4'(STABLE_CYC) && !(same && run_q == 4'(STABLE_CYC));
    multi_err = !one_hot && sel != '0 && !same;
    slot = '0;
    for (int k = 0; k < NUM_DIGITS; k++) if (sel[k]) slot = 4'(k);
  end

  // frame sequencing: hunt for slot 0, then capture slots in order up to the commit at slot 11
  always_comb begin
    state_d = state_q;
    exp_d = exp_q;
    to_d = to_q;
    locked_d = locked;
    wr = 1'b0;
    commit = 1'b0;
    seq_d = 1'b0;
    oh_d = 1'b0;
    if (multi_err) begin
      oh_d = 1'b1;
      state_d = HUNT;
      exp_d = '0;
      to_d = '0;
      locked_d = 1'b0;
    end else if (state_q == HUNT) begin
      to_d = '0;
      wr = accept && slot == '0;
      state_d = wr ? CAPTURE : HUNT;
      exp_d = wr ? 4'd1 : '0;
    end else if (accept) begin
      to_d = '0;
      if (slot == exp_q) begin
        wr = 1'b1;
        commit = slot == 4'(NUM_DIGITS - 1);
        exp_d = commit ? '0 : exp_q + 4'd1;
        locked_d = commit | locked;
      end else begin
        seq_d = 1'b1;
        locked_d = 1'b0;
        wr = slot == '0;
        exp_d = wr ? 4'd1 : '0;
        state_d = wr ? CAPTURE : HUNT;
      end
    end else if (to_q == 16'(TIMEOUT_CYC - 1)) begin
      state_d = HUNT;
      exp_d = '0;
      to_d = '0;
      locked_d = 1'b0;
    end else begin
      to_d = to_q + 16'd1;
    end
    done_d = commit;
    gl_d = wr && unk;
  end

  // input history, FSM state and registered status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q <= '0;
      segm_q <= '0;
      run_q <= '0;
      state_q <= HUNT;
      exp_q <= '0;
      to_q <= '0;
      locked <= 1'b0;
      frame_done <= 1'b0;
      err_seq <= 1'b0;
      err_onehot <= 1'b0;
      err_glyph <= 1'b0;
    end else begin
      sel_q <= sel;
      segm_q <= segm;
      run_q <= run_d;
      state_q <= state_d;
      exp_q <= exp_d;
      to_q <= to_d;
      locked <= locked_d;
      frame_done <= done_d;
      err_seq <= seq_d;
      err_onehot <= oh_d;
      err_glyph <= gl_d;
    end
  end

  // shadow fills slot by slot; the visible buffer is replaced in one edge on commit, slot 11 straight from the decoder
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow[i] <= CODE_SPACE;
        out_buf[i] <= CODE_SPACE;
      end
      rd_code <= CODE_SPACE;
    end else begin
      if (wr) shadow[slot] <= code;
      if (commit) begin
        for (int i = 0; i < NUM_DIGITS - 1; i++) out_buf[i] <= shadow[i];
        out_buf[NUM_DIGITS-1] <= code;
      end
      rd_code <= rd_addr < 4'(NUM_DIGITS) ? out_buf[rd_addr] : CODE_SPACE;
    end
  end

`ifdef SEG14_DEC_ERRCNT_EN
  logic [7:0] cnt_q;
  // one count per cycle carrying any error, held at 255
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else if ((oh_d | seq_d | gl_d) && cnt_q != 8'hff) cnt_q <= cnt_q + 8'd1;
  end
  assign err_cnt = cnt_q;
`else
  assign err_cnt = 8'd0;
`endif
endmodule

// File: tb/tb_seg14_scan_decoder.sv
// tb_seg14_scan_decoder: directed frames against a frame-level reference model plus literal spot checks
module tb_seg14_scan_decoder;
  localparam int STB = 1;
  localparam int TMO = 64;
`ifdef SEG14_DEC_ERRCNT_EN
  localparam int ERRCNT_ON = 1;
`else
  localparam int ERRCNT_ON = 0;
`endif
  localparam logic [13:0] GT [38] = '{
    14'b00000000000000, 14'b11101111000000, 14'b11110001010010, 14'b10011100000000,
    14'b11110000010010, 14'b10011111000000, 14'b10001110000000, 14'b10111101000000,
    14'b01101111000000, 14'b10010000010010, 14'b01111000000000, 14'b00001110001001,
    14'b00011100000000, 14'b01101100101000, 14'b01101100100001, 14'b11111100000000,
    14'b11001111000000, 14'b11111100000001, 14'b11001111000001, 14'b10110111000000,
    14'b10000000010010, 14'b01111100000000, 14'b00001100001100, 14'b01101100000101,
    14'b00000000101101, 14'b00000000101010, 14'b10010000001100, 14'b11101100100001,
    14'b11111100001100, 14'b01100000001000, 14'b11011011000000, 14'b11110001000000,
    14'b01100111000000, 14'b10110111000000, 14'b10111111000000, 14'b11100000000000,
    14'b11111111000000, 14'b11110111000000
  };

  logic clk = 1'b0, rst_n;
  logic [11:0] sel, sel3;
  logic [13:0] segm, segm3;
  logic [3:0] rd_addr, rd_addr3;
  logic [5:0] rd_code, rd_code3;
  logic frame_done, locked, err_seq, err_onehot, err_glyph;
  logic done3, locked3, eseq3, eoh3, egl3;
  logic [7:0] err_cnt, ecnt3;

  int n_chk = 0, n_pass = 0, n_done = 0, n_done3 = 0, n_err3 = 0, d0;
  int txt [12];
  bit rd_sweep = 1'b1;

  int m_run, m_exp, m_idle, m_errs, m_s, m_c, m_n;
  bit m_hunt, m_acc;
  logic [11:0] m_psel;
  logic [13:0] m_pseg;
  int m_shadow [12];
  int m_frame [12];
  int e_rd, e_cnt;
  bit e_done, e_lock, e_seq, e_oh, e_gl;

  seg14_scan_decoder #(.STABLE_CYC(STB), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .sel(sel), .segm(segm), .rd_addr(rd_addr), .rd_code(rd_code),
    .frame_done(frame_done), .locked(locked), .err_seq(err_seq), .err_onehot(err_onehot),
    .err_glyph(err_glyph), .err_cnt(err_cnt));

  seg14_scan_decoder #(.STABLE_CYC(3), .TIMEOUT_CYC(TMO)) dut3 (
    .clk(clk), .rst_n(rst_n), .sel(sel3), .segm(segm3), .rd_addr(rd_addr3), .rd_code(rd_code3),
    .frame_done(done3), .locked(locked3), .err_seq(eseq3), .err_onehot(eoh3),
    .err_glyph(egl3), .err_cnt(ecnt3));

  always #5 clk = ~clk;

  task automatic cmp(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic int m_decode(input logic [13:0] g);
    for (int i = 0; i < 38; i++) if (GT[i] == g) return i;
    return 63;
  endfunction

  task automatic m_store(input int s, input int c);
    m_shadow[s] = c;
    e_gl = c == 63;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 0; m_psel = '0; m_pseg = '0; m_hunt = 1; m_exp = 0; m_idle = 0; m_errs = 0;
      for (int i = 0; i < 12; i++) begin m_shadow[i] = 0; m_frame[i] = 0; end
      e_rd = 0; e_cnt = 0; e_done = 0; e_lock = 0; e_seq = 0; e_oh = 0; e_gl = 0;
    end else begin
      e_rd = rd_addr < 12 ? m_frame[rd_addr] : 0;
      m_run = (sel == m_psel && segm == m_pseg) ? m_run + 1 : 1;
      m_psel = sel; m_pseg = segm;
      m_n = $countones(sel);
      m_s = $clog2(sel);
      m_c = m_decode(segm);
      m_acc = m_n == 1 && m_run == STB;
      e_done = 0; e_seq = 0; e_oh = 0; e_gl = 0;
      if (m_n > 1) begin
        if (m_run == 1) begin e_oh = 1; e_lock = 0; m_hunt = 1; m_exp = 0; m_idle = 0; end
      end else if (m_hunt) begin
        if (m_acc && m_s == 0) begin m_store(0, m_c); m_hunt = 0; m_exp = 1; m_idle = 0; end
      end else if (m_acc) begin
        m_idle = 0;
        if (m_s == m_exp) begin
          m_store(m_s, m_c);
          if (m_s == 11) begin m_frame = m_shadow; e_done = 1; e_lock = 1; m_exp = 0; end
          else m_exp++;
        end else begin
          e_seq = 1; e_lock = 0;
          if (m_s == 0) begin m_store(0, m_c); m_exp = 1; end
          else begin m_hunt = 1; m_exp = 0; end
        end
      end else begin
        m_idle++;
        if (m_idle == TMO) begin m_hunt = 1; e_lock = 0; m_idle = 0; m_exp = 0; end
      end
      if (e_oh || e_seq || e_gl) m_errs++;
      e_cnt = ERRCNT_ON ? (m_errs > 255 ? 255 : m_errs) : 0;
    end
  end

  always @(negedge clk) begin
    cmp("rd_code", rd_code, e_rd);
    cmp("frame_done", frame_done, e_done);
    cmp("locked", locked, e_lock);
    cmp("err_seq", err_seq, e_seq);
    cmp("err_onehot", err_onehot, e_oh);
    cmp("err_glyph", err_glyph, e_gl);
    cmp("err_cnt", err_cnt, e_cnt);
    if (frame_done) n_done++;
    if (done3) n_done3++;
    if (eseq3 || eoh3 || egl3) n_err3++;
  end

  task automatic cyc(input logic [11:0] s, input logic [13:0] g);
    sel = s; segm = g;
    if (rd_sweep) rd_addr = rd_addr + 4'd1;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc('0, '0);
  endtask

  task automatic slots(input int a, input int b);
    for (int k = a; k <= b; k++) cyc(12'(1 << k), GT[txt[k]]);
  endtask

  task automatic rd(input logic [3:0] a, input string name, input int exp);
    rd_sweep = 1'b0; rd_addr = a;
    cyc('0, '0);
    cmp(name, rd_code, exp);
    rd_sweep = 1'b1;
  endtask

  task automatic cyc3(input logic [11:0] s, input logic [13:0] g);
    sel3 = s; segm3 = g;
    @(posedge clk); #1;
  endtask

  initial begin
    sel = '0; segm = '0; rd_addr = '0; sel3 = '0; segm3 = '0; rd_addr3 = 4'd1; rst_n = 1'b0;
    repeat (2) @(posedge clk); #1;
    cmp("reset_locked", locked, 0);
    cmp("reset_rd_code", rd_code, 0);
    cmp("reset_frame_done", frame_done, 0);
    cmp("reset_err_cnt", err_cnt, 0);
    rst_n = 1'b1;
    txt = '{19, 1, 14, 20, 9, 1, 7, 15, 0, 0, 0, 0};
    d0 = n_done; slots(0, 11); idle(1);
    cmp("santiago_done", n_done - d0, 1);
    cmp("santiago_locked", locked, 1);
    rd(1, "santiago_rd1_A", 1);
    rd(8, "santiago_rd8_space", 0);
    rd(0, "santiago_rd0_S", 19);
    rd(13, "rd_addr13_zero", 0);
    d0 = n_done; slots(0, 4); cyc(12'(1 << 6), GT[txt[6]]);
    cmp("skip_err_seq", err_seq, 1);
    cmp("skip_locked", locked, 0);
    slots(7, 11); idle(1);
    cmp("skip_no_done", n_done - d0, 0);
    rd(1, "skip_buf_kept", 1);
    txt = '{28, 29, 30, 31, 32, 33, 34, 35, 36, 37, 1, 2};
    d0 = n_done; slots(0, 11); idle(1);
    cmp("frame2_done", n_done - d0, 1);
    rd(5, "digit5_reads_S", 19);
    rd(0, "frame2_rd0", 28);
    slots(0, 3); cyc(12'b000000000011, '0);
    cmp("onehot_err", err_onehot, 1);
    cmp("onehot_locked", locked, 0);
    d0 = n_done; slots(4, 11); idle(1);
    cmp("onehot_no_done", n_done - d0, 0);
    rd(0, "onehot_buf_kept", 28);
    txt = '{19, 1, 14, 20, 9, 1, 7, 15, 0, 0, 0, 0};
    d0 = n_done; slots(0, 2); cyc(12'(1 << 3), 14'b00000000000001);
    cmp("glyph_err", err_glyph, 1);
    slots(4, 11); idle(1);
    cmp("glyph_done", n_done - d0, 1);
    rd(3, "glyph_rd3_unknown", 63);
    d0 = n_done; slots(0, 4); idle(63);
    cmp("timeout_locked_63", locked, 1);
    idle(1);
    cmp("timeout_locked_64", locked, 0);
    slots(5, 11); idle(1);
    cmp("timeout_no_done", n_done - d0, 0);
    slots(0, 5); rst_n = 1'b0; idle(2);
    cmp("midrst_locked", locked, 0);
    cmp("midrst_rd_code", rd_code, 0);
    rst_n = 1'b1;
    d0 = n_done; slots(6, 11); idle(1);
    cmp("midrst_no_done", n_done - d0, 0);
    rd(0, "midrst_buf_cleared", 0);
    slots(0, 11); idle(1);
    cmp("post_rst_done", n_done - d0, 1);
    d0 = n_done; slots(0, 2); cyc(12'd1, GT[txt[0]]);
    cmp("restart_err_seq", err_seq, 1);
    slots(1, 11); idle(1);
    cmp("restart_done", n_done - d0, 1);
    cmp("restart_locked", locked, 1);
    d0 = n_done;
    for (int k = 0; k < 12; k++) repeat (2) cyc(12'(1 << k), GT[txt[k]]);
    idle(1);
    cmp("hold2_single_accept", n_done - d0, 1);
    repeat (150) begin cyc(12'b000000000011, '0); cyc(12'b000000000101, '0); end
    idle(1);
    cmp("err_cnt_sat", err_cnt, ERRCNT_ON ? 255 : 0);
    for (int k = 0; k < 12; k++) repeat (2) cyc3(12'(1 << k), GT[txt[k]]);
    cyc3('0, '0); cyc3('0, '0);
    cmp("stable3_hold2_no_done", n_done3, 0);
    cmp("stable3_hold2_unlocked", locked3, 0);
    for (int k = 0; k < 12; k++) repeat (3) cyc3(12'(1 << k), GT[txt[k]]);
    cyc3('0, '0); cyc3('0, '0);
    cmp("stable3_hold3_done", n_done3, 1);
    cmp("stable3_locked", locked3, 1);
    cmp("stable3_rd1_A", rd_code3, 1);
    cmp("stable3_no_errors", n_err3, 0);
    cmp("stable3_err_cnt", ecnt3, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/seg14_scan_decoder.md
SEG14_SCAN_DECODER -- requirements
Module: seg14_scan_decoder

Interface
REQ-001 Parameter STABLE_CYC, default 1: consecutive identical cycles of sel/segm required to accept a slot (range 1-15).
REQ-002 Parameter TIMEOUT_CYC, default 64: idle cycles in CAPTURE before the block drops lock.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 sel  input  12  one-hot digit select from the scanned 14-segment display; bit k is digit k.
REQ-006 segm  input  14  segment pattern for the selected digit, bit 13 = segment a.
REQ-007 rd_addr  input  4  frame-buffer read index, 0-11.
REQ-008 rd_code  output  6  registered character code at rd_addr.
REQ-009 frame_done  output  1  one-cycle pulse when a complete frame is committed.
REQ-010 locked  output  1  high while in-order frames are being received.
REQ-011 err_seq / err_onehot / err_glyph  output  1 each  one-cycle error pulses.
REQ-012 err_cnt  output  8  saturating error count (see Configuration).

Function
REQ-013 Codes: 0 space (14'b0), 1-26 A-Z, 27 Ñ, 28-37 digits 0-9, 63 unknown; on duplicate patterns the letter wins ('S' = 14'b10110111000000, never '5').
REQ-014 A slot is accepted when sel is one-hot and sel/segm are unchanged for STABLE_CYC cycles; each stable run is accepted exactly once.
REQ-015 sel == 0: idle; no acceptance, no error, timeout counter runs.
REQ-016 sel with more than one bit set: err_onehot pulses, any in-progress frame is discarded, state -> HUNT.
REQ-017 Unknown segm pattern: slot is stored as 63 and err_glyph pulses; frame sequencing continues.
REQ-018 FSM HUNT: ignore slots other than 0; accepting slot 0 writes the shadow buffer entry 0 and sets expected = 1, state -> CAPTURE.
REQ-019 FSM CAPTURE: accepting slot == expected writes the shadow entry; expected increments.
REQ-020 FSM CAPTURE: accepting slot 11 as expected copies the shadow buffer to the output buffer on the same edge; frame_done and locked = 1 on the next cycle; expected wraps to 0.
REQ-021 FSM CAPTURE: accepting a slot != expected pulses err_seq and clears locked; that slot is 0 -> restart the frame, otherwise -> HUNT.
REQ-022 FSM CAPTURE: TIMEOUT_CYC cycles without an acceptance -> HUNT, locked = 0, no error pulse.
REQ-023 Output buffer changes only on commit; a partial frame is never visible.
REQ-024 rd_code reflects rd_addr one cycle later; rd_addr 12-15 returns 0; a read on the commit edge returns the new frame one cycle later.
REQ-025 Simultaneous error sources in one cycle: err_onehot takes priority over err_seq; err_cnt increments by 1.

Reset
REQ-026 When rst_n is low: state = HUNT, expected = 0, all output-buffer and shadow entries = 0 (space), rd_code = 0, all pulses = 0, locked = 0, err_cnt = 0, counters cleared.
REQ-027 Reset asserted mid-frame discards the frame; no frame_done follows deassertion until a full new frame is received.

Configuration
REQ-028 SEG14_DEC_ERRCNT_EN defined: err_cnt counts err_seq/err_onehot/err_glyph events and saturates at 255.
REQ-029 SEG14_DEC_ERRCNT_EN undefined: err_cnt is tied to 0 and no counter logic exists.

Structure
REQ-030 Package seg14_pkg holds: NUM_DIGITS = 12, the 6-bit code constants, glyph pattern constants, and the FSM state typedef.
REQ-031 Sub-module seg14_glyph_decode: combinational segm-to-code lookup with an unknown flag; it is instantiated once.

Verification
REQ-032 Drive sel 1<<k for k = 0..11 with "SANTIAGO" plus 4 spaces, one cycle each -> one frame_done pulse; rd_addr 1 reads 1 ('A'); rd_addr 8 reads 0.
REQ-033 Skip slot 5 (4 followed by 6) -> err_seq pulse, locked = 0, no frame_done; the next clean frame commits.
REQ-034 sel = 12'b000000000011 mid-frame -> err_onehot pulse, state HUNT; the previous output buffer is unchanged.
REQ-035 segm = 14'b00000000000001 on slot 3 -> err_glyph pulse; after commit, rd_addr 3 reads 63.
REQ-036 sel held at 0 for 64 cycles after slot 4 -> locked = 0; slots 5..11 that follow produce no frame_done.
REQ-037 With STABLE_CYC = 3, each slot is held 2 cycles -> no acceptance; each slot is held 3 cycles -> frame_done; with the macro on, 300 errors -> err_cnt = 255.
